// File: rtl/aes_pkg.sv
// Shared definitions for the AES block sequencer: FSM encoding, key-length codes and default limits.
// Pure declarations; no logic.
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    KEY_INIT = 3'd1,
    KEY_WAIT = 3'd2,
    BLK_NEXT = 3'd3,
    BLK_WAIT = 3'd4
  } seq_state_e;

  localparam logic KEYLEN_AES128 = 1'b0;
  localparam logic KEYLEN_AES256 = 1'b1;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int BLOCK_W         = 128;
  localparam int KEY_W           = 256;
  localparam int WAIT_CNT_W      = 8;

endpackage

// File: rtl/aes_result_fifo.sv
// Result buffer: head visible combinationally, one-cycle push-to-valid latency.
// Pop only when non-empty; the producer is expected to check full before pushing.
module aes_result_fifo #(
  parameter int OUT_DEPTH = 2,
  parameter int WIDTH     = 128
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             full
);

  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(OUT_DEPTH);

  logic [WIDTH-1:0] mem [OUT_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign valid  = (count != '0);
  assign full   = (count == DEPTH_C);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/aes_block_sequencer.sv
// Sequences key expansion and single-block operations on an AES core, buffering results in a FIFO.
// Transfer->core_next 1 cycle, core result->out_valid 1 cycle; in_ready drops when the FIFO has no free slot.
module aes_block_sequencer
  import aes_pkg::*;
#(
  parameter int OUT_DEPTH = 2,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               key_load,
  input  logic [KEY_W-1:0]   key,
  input  logic               keylen,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_block,
  input  logic               in_encdec,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               core_init,
  output logic               core_next,
  output logic               core_encdec,
  output logic [KEY_W-1:0]   core_key,
  output logic               core_keylen,
  output logic [BLOCK_W-1:0] core_block,
  input  logic               core_ready,
  input  logic [BLOCK_W-1:0] core_result,
  input  logic               core_result_valid,
  output logic               key_valid,
  output logic               busy,
  output logic               err
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(TIMEOUT);

  seq_state_e            state;
  seq_state_e            state_nxt;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  first_wait;
  logic                  wait_hit;
  logic                  fifo_full;
  logic                  load_key;
  logic                  xfer;
  logic                  key_done;
  logic                  timeout;
  logic                  push;

  assign first_wait = (wait_cnt == '0);
  assign wait_hit   = (wait_cnt == TIMEOUT_CNT);
  assign busy       = (state != IDLE);
  assign core_init  = (state == KEY_INIT);
  assign core_next  = (state == BLK_NEXT);
  // key_load gets priority, so it also masks acceptance in the same cycle.
  assign in_ready   = (state == IDLE) && key_valid && !key_load && !fifo_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_key  = 1'b0;
    xfer      = 1'b0;
    key_done  = 1'b0;
    timeout   = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (key_load) begin
          load_key  = 1'b1;
          state_nxt = KEY_INIT;
        end else if (in_valid && in_ready) begin
          xfer      = 1'b1;
          state_nxt = BLK_NEXT;
        end
      end
      KEY_INIT: state_nxt = KEY_WAIT;
      KEY_WAIT: begin
        // The core's ready may still reflect the previous operation on the first cycle.
        if (!first_wait && core_ready) begin
          key_done  = 1'b1;
          state_nxt = IDLE;
        end else if (wait_hit) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      BLK_NEXT: state_nxt = BLK_WAIT;
      BLK_WAIT: begin
        if (!first_wait && core_ready && core_result_valid) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end else if (wait_hit) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt    <= '0;
      key_valid   <= 1'b0;
      err         <= 1'b0;
      core_key    <= '0;
      core_keylen <= KEYLEN_AES128;
      core_block  <= '0;
      core_encdec <= 1'b0;
    end else begin
      // Wait states are only ever entered from KEY_INIT / BLK_NEXT.
      if (state == KEY_INIT || state == BLK_NEXT)
        wait_cnt <= '0;
      else if (state == KEY_WAIT || state == BLK_WAIT)
        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);

      if (load_key) begin
        core_key    <= key;
        core_keylen <= keylen;
        key_valid   <= 1'b0;
        err         <= 1'b0;
      end
      if (key_done) key_valid <= 1'b1;
      if (timeout) begin
        err       <= 1'b1;
        key_valid <= 1'b0;
      end
      if (xfer) begin
        core_block  <= in_block;
        core_encdec <= in_encdec;
      end
    end
  end

  aes_result_fifo #(
    .OUT_DEPTH (OUT_DEPTH),
    .WIDTH     (BLOCK_W)
  ) u_result_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (core_result),
    .pop       (out_ready),
    .valid     (out_valid),
    .head      (out_data),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Directed bench for aes_block_sequencer with a behavioural cipher-core model and a result scoreboard.
module tb_aes_block_sequencer;

  localparam int OUT_DEPTH = 2;
  localparam int TIMEOUT   = 255;
  localparam int CORE_LAT  = 4;

  localparam logic [255:0] KEY_A  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_B  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] PT_A   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_A   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MASK_E = 128'h5a5a5a5a0f0f0f0f123456789abcdef0;
  localparam logic [127:0] MASK_D = 128'hc3c3c3c3f0f0f0f0fedcba9876543210;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         key_load;
  logic [255:0] key;
  logic         keylen;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic         in_encdec;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         core_init;
  logic         core_next;
  logic         core_encdec;
  logic [255:0] core_key;
  logic         core_keylen;
  logic [127:0] core_block;
  logic         core_ready;
  logic [127:0] core_result;
  logic         core_result_valid;
  logic         key_valid;
  logic         busy;
  logic         err;

  int           vectors = 0;
  int           miscompares = 0;
  logic [127:0] exp_q[$];
  logic         hang = 1'b0;
  int           init_pulses = 0;
  int           next_pulses = 0;
  int           lat_cnt;
  logic         pend_blk;

  always #5 clk = ~clk;

  aes_block_sequencer #(.OUT_DEPTH(OUT_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .key_load(key_load), .key(key), .keylen(keylen),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block), .in_encdec(in_encdec),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_init(core_init), .core_next(core_next), .core_encdec(core_encdec),
    .core_key(core_key), .core_keylen(core_keylen), .core_block(core_block),
    .core_ready(core_ready), .core_result(core_result), .core_result_valid(core_result_valid),
    .key_valid(key_valid), .busy(busy), .err(err)
  );

  // Known FIPS-197 vector for KEY_A, otherwise an arbitrary key/direction-dependent mix.
  function automatic logic [127:0] core_fn(input logic [255:0] k, input logic kl,
                                           input logic [127:0] b, input logic enc);
    if (k == KEY_A && kl == 1'b0 && enc && b == PT_A) return CT_A;
    if (k == KEY_A && kl == 1'b0 && !enc && b == CT_A) return PT_A;
    return b ^ k[255:128] ^ k[127:0] ^ (enc ? MASK_E : MASK_D) ^ {127'h0, kl};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_ready        <= 1'b1;
      core_result_valid <= 1'b0;
      core_result       <= '0;
      lat_cnt           <= 0;
      pend_blk          <= 1'b0;
    end else if (core_init) begin
      core_ready        <= 1'b0;
      core_result_valid <= 1'b0;
      lat_cnt           <= CORE_LAT;
      pend_blk          <= 1'b0;
    end else if (core_next) begin
      core_ready        <= 1'b0;
      core_result_valid <= 1'b0;
      lat_cnt           <= CORE_LAT;
      pend_blk          <= 1'b1;
      core_result       <= core_fn(core_key, core_keylen, core_block, core_encdec);
    end else if (lat_cnt != 0 && !(hang && pend_blk)) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) begin
        core_ready        <= 1'b1;
        core_result_valid <= pend_blk;
      end
    end
  end

  always @(posedge clk) begin
    if (core_init) init_pulses <= init_pulses + 1;
    if (core_next) next_pulses <= next_pulses + 1;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted output handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      chk1("out_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk128("out_data", out_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key_op(input logic [255:0] k, input logic kl);
    int   p0 = init_pulses;
    logic ir_seen = 1'b0;
    logic got = 1'b0;
    key = k; keylen = kl; key_load = 1'b1;
    @(negedge clk);
    chk1("in_ready_during_key_load", in_ready, 1'b0);
    tick();
    key_load = 1'b0;
    @(negedge clk);
    chk1("core_init_pulse", core_init, 1'b1);
    chk256("core_key", core_key, k);
    chk1("core_keylen", core_keylen, kl);
    chk1("key_valid_cleared", key_valid, 1'b0);
    chk1("err_cleared", err, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (key_valid) begin got = 1'b1; break; end
      if (in_ready) ir_seen = 1'b1;
    end
    chk1("key_valid_set", got, 1'b1);
    chk1("in_ready_before_key_valid", ir_seen, 1'b0);
    chk1("core_init_once", (init_pulses - p0) == 1, 1'b1);
  endtask

  task automatic send(input logic [127:0] blk, input logic enc,
                      input logic expect_out, input logic [127:0] exp);
    logic got = 1'b0;
    in_block = blk; in_encdec = enc; in_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    chk1("in_accept", got, 1'b1);
    if (got && expect_out) exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk1("core_next_after_xfer", core_next, 1'b1);
    chk128("core_block", core_block, blk);
    chk1("core_encdec", core_encdec, enc);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk1(tag, busy, 1'b0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk1("scoreboard_drained", exp_q.size() == 0, 1'b1);
  endtask

  initial begin
    logic [127:0] e1, e2, e3, e4, e6;
    logic         got, ov, early;
    int           n, p_next;

    reset_n = 1'b0; key_load = 1'b0; key = '0; keylen = 1'b0;
    in_valid = 1'b0; in_block = '0; in_encdec = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_key_valid", key_valid, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_core_init", core_init, 1'b0);
    chk1("rst_core_next", core_next, 1'b0);
    chk256("rst_core_key", core_key, '0);
    chk128("rst_core_block", core_block, '0);
    tick();
    reset_n = 1'b1;

    // Known-answer encrypt/decrypt with AES-128 key.
    tick();
    load_key_op(KEY_A, 1'b0);
    tick();
    out_ready = 1'b1;
    send(PT_A, 1'b1, 1'b1, CT_A);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (core_result_valid && core_ready) begin got = 1'b1; break; end
    end
    @(negedge clk);
    chk1("result_to_out_valid", got && out_valid, 1'b1);
    wait_drain();
    tick();
    send(CT_A, 1'b0, 1'b1, PT_A);
    wait_drain();

    // Backpressure: two results fill the FIFO, the third block waits.
    e1 = core_fn(KEY_A, 1'b0, 128'hdeadbeef_00000001_cafef00d_12345678, 1'b1);
    e2 = core_fn(KEY_A, 1'b0, 128'h0badc0de_ffffffff_00000000_a5a5a5a5, 1'b0);
    e3 = core_fn(KEY_A, 1'b0, 128'h13579bdf_2468ace0_fedcba98_01234567, 1'b1);
    wait_idle("idle_before_bp");
    tick();
    out_ready = 1'b0;
    send(128'hdeadbeef_00000001_cafef00d_12345678, 1'b1, 1'b1, e1);
    wait_idle("idle_b1");
    tick();
    send(128'h0badc0de_ffffffff_00000000_a5a5a5a5, 1'b0, 1'b1, e2);
    wait_idle("idle_b2");
    @(negedge clk);
    chk1("bp_out_valid", out_valid, 1'b1);
    chk128("bp_head", out_data, e1);
    chk1("bp_in_ready_full", in_ready, 1'b0);
    tick();
    in_block = 128'h13579bdf_2468ace0_fedcba98_01234567; in_encdec = 1'b1; in_valid = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk1("bp_third_blocked", in_ready, 1'b0);
    chk1("bp_third_not_busy", busy, 1'b0);
    chk128("bp_head_stable", out_data, e1);
    exp_q.push_back(e3);
    tick();
    out_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    chk1("bp_third_accepted", got, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk1("bp_third_core_next", core_next, 1'b1);
    wait_drain();

    // key_load beats a simultaneous in_valid; AES-256 key.
    wait_idle("idle_before_prio");
    tick();
    p_next = next_pulses;
    e4 = core_fn(KEY_B, 1'b1, 128'h00000000_11111111_22222222_33333333, 1'b1);
    in_block = 128'h00000000_11111111_22222222_33333333; in_encdec = 1'b1; in_valid = 1'b1;
    load_key_op(KEY_B, 1'b1);
    chk1("prio_no_core_next", next_pulses == p_next, 1'b1);
    chk1("prio_in_ready_after_key", in_ready, 1'b1);
    exp_q.push_back(e4);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk1("prio_core_next", core_next, 1'b1);
    wait_drain();

    // Core never answers the block: timeout.
    wait_idle("idle_before_to");
    tick();
    hang = 1'b1;
    send(128'hffffffff_eeeeeeee_dddddddd_cccccccc, 1'b1, 1'b0, '0);
    n = 0; ov = 1'b0; early = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (out_valid) ov = 1'b1;
      if (err) begin n = i; break; end
    end
    chk1("to_err_set", n != 0, 1'b1);
    chk1("to_err_window", n >= TIMEOUT && n <= TIMEOUT + 5, 1'b1);
    chk1("to_key_valid", key_valid, 1'b0);
    chk1("to_idle", busy, 1'b0);
    chk1("to_out_valid_never", ov, 1'b0);
    chk1("to_in_ready", in_ready, 1'b0);
    repeat (3) tick();
    @(negedge clk);
    chk1("to_err_sticky", err, 1'b1);
    tick();
    hang = 1'b0;
    load_key_op(KEY_A, 1'b0);

    // Reset in BLK_WAIT with one buffered result.
    tick();
    out_ready = 1'b0;
    e6 = core_fn(KEY_A, 1'b0, 128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b1);
    send(128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b1, 1'b0, '0);
    wait_idle("idle_b6");
    @(negedge clk);
    chk1("rs_one_entry", out_valid, 1'b1);
    chk128("rs_entry_data", out_data, e6);
    tick();
    hang = 1'b1;
    send(128'h11223344_55667788_99aabbcc_ddeeff00, 1'b0, 1'b0, '0);
    repeat (3) tick();
    @(negedge clk);
    chk1("rs_in_blk_wait", busy, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk1("rs_async_busy", busy, 1'b0);
    chk1("rs_async_out_valid", out_valid, 1'b0);
    chk1("rs_async_key_valid", key_valid, 1'b0);
    chk128("rs_async_core_block", core_block, '0);
    chk1("rs_async_in_ready", in_ready, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    hang = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk1("rs_post_key_valid", key_valid, 1'b0);
    chk1("rs_post_out_valid", out_valid, 1'b0);
    chk1("rs_post_in_ready", in_ready, 1'b0);
    chk1("scoreboard_empty", exp_q.size() == 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
